aes_128_sched: RTL and testbench

- Issue controller and two-requester arbiter in front of the fully pipelined, stall-free AES-128 core.
- Round-robin arbitration between two plaintext/key request channels; at most one block enters the core per clock.
- Tracks in-flight blocks with a valid/source/tag shadow pipeline matched to the core latency.
- Captures results into an output FIFO with valid/ready backpressure. Credit-based issue ensures the non-stallable core never loses a result.

---
 rtl/aes_128_sched.sv | 143 ++++++++++++++
 tb/tb_aes_128_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_sched.sv
// Two-requester round-robin issue, credit control and result FIFO for a
// stall-free AES-128 core. Perf counters built in when AES_SCHED_PERF_EN is set.
module aes_128_sched #(
    parameter int LATENCY    = 21,
    parameter int FIFO_DEPTH = 32,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [127:0]     req0_state,
    input  logic [127:0]     req0_key,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [127:0]     req1_state,
    input  logic [127:0]     req1_key,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [127:0]     core_state,
    output logic [127:0]     core_key,
    input  logic [127:0]     core_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = TAG_W + 2;
    localparam int EW = 128 + 1 + TAG_W;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [CW-1:0]  r_inflight;
    logic [CW-1:0]  r_count;
    logic [PW-1:0]  r_wp;
    logic [PW-1:0]  r_rp;
    logic           r_last;
    logic [SW-1:0]  r_shd [LATENCY+1];
    logic [EW-1:0]  r_mem [FIFO_DEPTH];

    logic             w_can;
    logic             w_g0;
    logic             w_g1;
    logic             w_issue;
    logic [TAG_W-1:0] w_tag;
    logic             w_wr;
    logic             w_rd;
    logic [EW-1:0]    w_head;

    // Credit covers every block that will eventually need a FIFO slot.
    assign w_can   = ({1'b0, r_inflight} + {1'b0, r_count}) < DEPTH_C;
    assign w_g0    = w_can & req0_valid & (~req1_valid | r_last);
    assign w_g1    = w_can & req1_valid & (~req0_valid | ~r_last);
    assign w_issue = w_g0 | w_g1;
    assign w_tag   = w_g1 ? req1_tag : req0_tag;

    assign req0_ready = w_g0;
    assign req1_ready = w_g1;
    assign core_state = w_g0 ? req0_state : (w_g1 ? req1_state : '0);
    assign core_key   = w_g0 ? req0_key : (w_g1 ? req1_key : '0);

    assign w_wr   = r_shd[LATENCY][SW-1];
    assign w_rd   = out_valid & out_ready;
    assign w_head = r_mem[r_rp];

    assign out_valid = r_count != '0;
    assign out_data  = out_valid ? w_head[EW-1 -: 128] : '0;
    assign out_src   = out_valid ? w_head[TAG_W] : 1'b0;
    assign out_tag   = out_valid ? w_head[TAG_W-1:0] : '0;
    assign busy      = (r_inflight != '0) | (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
            for (int i = 0; i <= LATENCY; i++) r_shd[i] <= '0;
        end else begin
            if (w_issue) r_last <= w_g1;
            r_shd[0] <= w_issue ? {1'b1, w_g1, w_tag} : '0;
            for (int i = 1; i <= LATENCY; i++) r_shd[i] <= r_shd[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_wr})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= {core_out, r_shd[LATENCY][TAG_W:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + PW'(1);
            if (w_rd) r_rp <= r_rp + PW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef AES_SCHED_PERF_EN
    logic [31:0] r_perf_iss;
    logic [31:0] r_perf_stl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_iss <= '0;
            r_perf_stl <= '0;
        end else begin
            if (w_issue && r_perf_iss != '1) r_perf_iss <= r_perf_iss + 32'd1;
            if ((req0_valid | req1_valid) && !w_can && r_perf_stl != '1)
                r_perf_stl <= r_perf_stl + 32'd1;
        end
    end

    assign perf_issued = r_perf_iss;
    assign perf_stall  = r_perf_stl;
`else
    assign perf_issued = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_aes_128_sched.sv
// Bench for aes_128_sched: behavioural AES core, per-requester source queues
// and an in-order expected-result queue built from a plain AES model.
module tb_aes_128_sched;

    localparam int LATENCY = 21;
    localparam int TAG_W   = 8;

    typedef struct packed {
        logic [127:0] pt;
        logic [127:0] key;
        logic [7:0]   tag;
    } blk_t;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [127:0]     req0_state, req1_state, req0_key, req1_key;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [127:0]     core_state, core_key, core_out;
    logic             out_valid, out_ready, out_src, busy;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      perf_issued, perf_stall;

    aes_128_sched #(.LATENCY(LATENCY), .FIFO_DEPTH(32), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_state(req0_state), .req0_key(req0_key), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_state(req1_state), .req1_key(req1_key), .req1_tag(req1_tag),
        .core_state(core_state), .core_key(core_key), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_tag(out_tag), .busy(busy),
        .perf_issued(perf_issued), .perf_stall(perf_stall)
    );

    logic [7:0] sbox [256];
    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] aes(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [31:0] tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*((c+k)%4)+k];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                        s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++) s[4*c+k] = s[4*c+k] ^ w[4*r+c][31-8*k -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Behavioural core: fixed-latency, non-stallable
    logic [127:0] cp [LATENCY+1];
    always @(posedge clk) begin
        cp[0] <= aes(core_state, core_key);
        for (int i = 1; i <= LATENCY; i++) cp[i] <= cp[i-1];
    end
    assign core_out = cp[LATENCY];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    blk_t s0[$];
    blk_t s1[$];
    logic [136:0] exp_q[$];
    logic en0 = 1'b1, en1 = 1'b1;
    logic chk_rr = 1'b0;
    logic exp_rr = 1'b0;
    int ncyc = 0, issued = 0, delivered = 0, first_out = -1, last_out = 0, last_issue = 0;
    logic [127:0] last_data;

    task automatic check(input string name, input logic [136:0] obs, input logic [136:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    function automatic blk_t rnd_blk();
        blk_t b;
        b.pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
        b.key = {$urandom(), $urandom(), $urandom(), $urandom()};
        b.tag = 8'($urandom_range(0, 255));
        return b;
    endfunction

    task automatic drive();
        req0_valid = en0 && s0.size() != 0;
        req1_valid = en1 && s1.size() != 0;
        if (s0.size() != 0) begin
            req0_state = s0[0].pt; req0_key = s0[0].key; req0_tag = s0[0].tag;
        end else begin
            req0_state = '0; req0_key = '0; req0_tag = '0;
        end
        if (s1.size() != 0) begin
            req1_state = s1[0].pt; req1_key = s1[0].key; req1_tag = s1[0].tag;
        end else begin
            req1_state = '0; req1_key = '0; req1_tag = '0;
        end
    endtask

    task automatic cyc();
        logic g0, g1;
        logic [136:0] e;
        blk_t b;
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            g0 = req0_valid && req0_ready;
            g1 = req1_valid && req1_ready;
            if (chk_rr && (req0_valid || req1_valid)) begin
                check("rr_grant", {g1, g0}, exp_rr ? 2'b10 : 2'b01);
                exp_rr = ~exp_rr;
            end
            if (g0) begin
                b = s0.pop_front();
                exp_q.push_back({aes(b.pt, b.key), 1'b0, b.tag});
                issued++; last_issue = ncyc;
            end
            if (g1) begin
                b = s1.pop_front();
                exp_q.push_back({aes(b.pt, b.key), 1'b1, b.tag});
                issued++; last_issue = ncyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_head", {out_data, out_src, out_tag}, e);
                    delivered++;
                    last_data = out_data;
                    if (first_out < 0) first_out = ncyc;
                    last_out = ncyc;
                end
            end
        end
        @(negedge clk);
        ncyc++;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        s0.delete(); s1.delete();
        drive();
        cyc();
        rst = 1'b0;
        issued = 0; delivered = 0; first_out = -1; chk_rr = 1'b0;
    endtask

    initial begin
        logic [7:0] inv, sv;
        blk_t fb;
        int guard;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sv = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = sv;
        end
        rst = 1'b1; out_ready = 1'b0;
        drive();
        @(negedge clk);
        reset_dut();

        // Reset state
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out", {out_data, out_src, out_tag}, '0);
        check("rst_core", {core_state, core_key}, '0);
        check("rst_perf", {perf_issued, perf_stall}, '0);

        // FIPS-197 vector on req0
        out_ready = 1'b1;
        fb.pt = 128'h00112233445566778899aabbccddeeff;
        fb.key = 128'h000102030405060708090a0b0c0d0e0f;
        fb.tag = 8'h3c;
        s0.push_back(fb);
        drive();
        #1;
        check("fips_ready", req0_ready, 1'b1);
        check("fips_core", {core_state, core_key}, {fb.pt, fb.key});
        for (int i = 0; i < 60 && delivered < 1; i++) begin drive(); cyc(); end
        check("fips_done", delivered, 1);
        check("fips_latency", first_out - last_issue - 1, LATENCY + 1);
        check("fips_ct", last_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("fips_busy", busy, 1'b0);

        // Both requesters streaming: strict alternation, no bubbles
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin s0.push_back(rnd_blk()); s1.push_back(rnd_blk()); end
        chk_rr = 1'b1; exp_rr = 1'b0;
        for (int i = 0; i < 200 && delivered < 48; i++) begin drive(); cyc(); end
        chk_rr = 1'b0;
        check("rr_done", delivered, 48);
        check("rr_no_bubble", last_out - first_out + 1, 48);

        // Backpressure: credit stops issue at 32, then 10 blocked cycles
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) s0.push_back(rnd_blk());
        guard = 0;
        while (issued < 32 && guard < 200) begin drive(); cyc(); guard++; end
        check("bp_issued", issued, 32);
        for (int i = 0; i < 10; i++) begin
            drive(); cyc();
            check("bp_ready_low", req0_ready, 1'b0);
        end
        check("bp_issued_hold", issued, 32);
        #1;
`ifdef AES_SCHED_PERF_EN
        check("perf_counts", {perf_issued, perf_stall}, {32'd32, 32'd10});
`else
        check("perf_counts", {perf_issued, perf_stall}, '0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 400 && delivered < 40; i++) begin drive(); cyc(); end
        check("bp_delivered", delivered, 40);
        check("bp_queue_empty", exp_q.size(), 0);
        #1;
        check("bp_busy", busy, 1'b0);

        // 100 random blocks, random valid and out_ready: pointer wrap
        reset_dut();
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 1) == 0) s0.push_back(rnd_blk());
            else s1.push_back(rnd_blk());
        end
        for (int i = 0; i < 3000 && delivered < 100; i++) begin
            en0 = $urandom_range(0, 3) != 0;
            en1 = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 1) == 1;
            drive(); cyc();
        end
        en0 = 1'b1; en1 = 1'b1;
        check("wrap_delivered", delivered, 100);
        check("wrap_queue_empty", exp_q.size(), 0);

        // Reset with 5 results in FIFO and 10 blocks in flight
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) s0.push_back(rnd_blk());
        for (int i = 0; i < 30; i++) begin drive(); cyc(); end
        for (int i = 0; i < 10; i++) s1.push_back(rnd_blk());
        for (int i = 0; i < 10; i++) begin drive(); cyc(); end
        check("mid_issued", issued, 15);
        reset_dut();
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_busy", busy, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 2 * LATENCY; i++) begin
            drive(); cyc();
            check("mid_quiet", out_valid, 1'b0);
        end
        s0.push_back(rnd_blk());
        for (int i = 0; i < 60 && delivered < 1; i++) begin drive(); cyc(); end
        check("mid_new_done", delivered, 1);
        check("mid_new_latency", first_out - last_issue - 1, LATENCY + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
